// File: rtl/gpio_padctl.sv
// gpio_padctl: core-side controller for the bidirectional padring pads.
// APB slave with output data, per-pad control words, synchronised input
// sampling, edge detection and a level interrupt. gpio bit n maps to pad n+3.
module gpio_padctl #(
  parameter int                   NUM_GPIO  = 16,
  parameter int                   PAD_CTL_W = 9,
  parameter logic [PAD_CTL_W-1:0] CTL_RST   = 9'h003
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [11:0]                   paddr,
  input  logic [31:0]                   pwdata,
  output logic [31:0]                   prdata,
  output logic                          pready,
  output logic                          pslverr,
  output logic [NUM_GPIO-1:0]           gpio_out,
  output logic [NUM_GPIO*PAD_CTL_W-1:0] gpio_ctl,
  input  logic [NUM_GPIO-1:0]           gpio_in,
  output logic                          irq
);

  localparam logic [9:0] A_DOUT  = 10'h000;
  localparam logic [9:0] A_DIN   = 10'h001;
  localparam logic [9:0] A_IE    = 10'h002;
  localparam logic [9:0] A_RISE  = 10'h003;
  localparam logic [9:0] A_FALL  = 10'h004;
  localparam logic [9:0] A_ISTAT = 10'h005;
  localparam logic [9:0] A_SET   = 10'h006;
  localparam logic [9:0] A_CLR   = 10'h007;

  logic [NUM_GPIO-1:0]  dout, ie, rise_en, fall_en, istat;
  logic [NUM_GPIO-1:0]  s1, s2, p;
  logic [NUM_GPIO-1:0]  rise, fall, w1c, wd;
  logic [PAD_CTL_W-1:0] ctl [NUM_GPIO];

  logic [9:0] widx;
  logic [5:0] cidx;
  logic       reg_hit, ctl_hit, access, wr, rd;
  logic [31:0] rdata;

  assign widx    = paddr[11:2];
  assign cidx    = paddr[7:2];
  assign reg_hit = (widx < 10'd8);
  assign ctl_hit = (paddr[11:8] == 4'h1) && ({26'd0, cidx} < 32'(NUM_GPIO));
  assign access  = psel & penable;
  assign wr      = access & pwrite;
  assign rd      = access & ~pwrite;
  assign wd      = pwdata[NUM_GPIO-1:0];

  assign pready   = 1'b1;
  assign pslverr  = access & ~(reg_hit | ctl_hit);
  assign prdata   = rdata;
  assign gpio_out = dout;

  assign rise = s2 & ~p;
  assign fall = ~s2 & p;
  assign w1c  = (wr && widx == A_ISTAT) ? wd : '0;

  // Software-writable registers: data out, enables and pad control words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      ie      <= '0;
      rise_en <= '0;
      fall_en <= '0;
      for (int unsigned n = 0; n < NUM_GPIO; n++) ctl[n] <= CTL_RST;
    end else if (wr) begin
      if (reg_hit) begin
        case (widx)
          A_DOUT:  dout    <= wd;
          A_IE:    ie      <= wd;
          A_RISE:  rise_en <= wd;
          A_FALL:  fall_en <= wd;
          A_SET:   dout    <= dout | wd;
          A_CLR:   dout    <= dout & ~wd;
          default: ;
        endcase
      end
      for (int unsigned n = 0; n < NUM_GPIO; n++) begin
        if (ctl_hit && cidx == n[5:0]) ctl[n] <= pwdata[PAD_CTL_W-1:0];
      end
    end
  end

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      p  <= '0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
      p  <= s2;
    end
  end

  // Sticky edge status (a new edge beats a same-cycle clear) and registered irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      istat <= '0;
      irq   <= 1'b0;
    end else begin
      istat <= (istat & ~w1c) | (rise & rise_en) | (fall & fall_en);
      irq   <= |(istat & ie);
    end
  end

  // Access-phase read mux; everything else reads zero.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (reg_hit) begin
        case (widx)
          A_DOUT:  rdata[NUM_GPIO-1:0] = dout;
          A_DIN:   rdata[NUM_GPIO-1:0] = s2;
          A_IE:    rdata[NUM_GPIO-1:0] = ie;
          A_RISE:  rdata[NUM_GPIO-1:0] = rise_en;
          A_FALL:  rdata[NUM_GPIO-1:0] = fall_en;
          A_ISTAT: rdata[NUM_GPIO-1:0] = istat;
          default: rdata = '0;
        endcase
      end else if (ctl_hit) begin
        for (int unsigned n = 0; n < NUM_GPIO; n++) begin
          if (cidx == n[5:0]) rdata[PAD_CTL_W-1:0] = ctl[n];
        end
      end
    end
  end

  // Flatten the control words onto the padring bus.
  always_comb begin
    gpio_ctl = '0;
    for (int unsigned n = 0; n < NUM_GPIO; n++) begin
      gpio_ctl[n*PAD_CTL_W +: PAD_CTL_W] = ctl[n];
    end
  end

endmodule

// File: tb/tb_gpio_padctl.sv
// tb_gpio_padctl: directed plus randomized bench with a behavioural model.
module tb_gpio_padctl;

  localparam int N = 16;
  localparam int W = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           psel, penable, pwrite;
  logic [11:0]    paddr;
  logic [31:0]    pwdata;
  logic [31:0]    prdata;
  logic           pready, pslverr;
  logic [N-1:0]   gpio_out;
  logic [N*W-1:0] gpio_ctl;
  logic [N-1:0]   gpio_in;
  logic           irq;

  always #5 clk = ~clk;

  gpio_padctl #(.NUM_GPIO(N), .PAD_CTL_W(W), .CTL_RST(9'h003)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .gpio_out(gpio_out), .gpio_ctl(gpio_ctl),
    .gpio_in(gpio_in), .irq(irq)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: register values plus a queue holding the last two
  // pad samples, so DIN is simply the pad value seen two clocks ago.
  logic [N-1:0] m_dout, m_ie, m_re, m_fe, m_ist, m_din_prev;
  logic [W-1:0] m_ctl [N];
  logic         m_irq;
  logic [N-1:0] seen [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = '0; m_ie = '0; m_re = '0; m_fe = '0; m_ist = '0;
    m_irq = 1'b0; m_din_prev = '0;
    for (int i = 0; i < N; i++) m_ctl[i] = 9'h003;
    seen.delete();
    seen.push_back('0);
    seen.push_back('0);
  endtask

  function automatic logic [N*W-1:0] m_ctl_packed();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = m_ctl[i];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int w;
    w = int'(a) / 4;
    case (w)
      0: return {16'h0, m_dout};
      1: return {16'h0, seen[0]};
      2: return {16'h0, m_ie};
      3: return {16'h0, m_re};
      4: return {16'h0, m_fe};
      5: return {16'h0, m_ist};
      default: if (w >= 64 && w < 64 + N) return {23'h0, m_ctl[w-64]};
    endcase
    return 32'h0;
  endfunction

  function automatic logic m_err(input logic [11:0] a);
    int w;
    w = int'(a) / 4;
    return !(w < 8 || (w >= 64 && w < 64 + N));
  endfunction

  // One clock: update the model from the current bus/pad state, then check outputs.
  task automatic tick();
    logic [N-1:0] d, w1c, nist;
    logic         nirq, wr;
    int           w;
    w    = int'(paddr) / 4;
    d    = pwdata[N-1:0];
    wr   = psel && penable && pwrite;
    w1c  = (wr && w == 5) ? d : '0;
    nist = (m_ist & ~w1c) | (seen[0] & ~m_din_prev & m_re) | (~seen[0] & m_din_prev & m_fe);
    nirq = |(m_ist & m_ie);
    if (wr) begin
      case (w)
        0: m_dout = d;
        2: m_ie = d;
        3: m_re = d;
        4: m_fe = d;
        6: m_dout = m_dout | d;
        7: m_dout = m_dout & ~d;
        default: if (w >= 64 && w < 64 + N) m_ctl[w-64] = pwdata[W-1:0];
      endcase
    end
    @(posedge clk);
    #1;
    m_ist = nist;
    m_irq = nirq;
    m_din_prev = seen[0];
    void'(seen.pop_front());
    seen.push_back(gpio_in);
    chk("gpio_out", gpio_out, m_dout);
    chk("gpio_ctl", gpio_ctl, m_ctl_packed());
    chk("irq", irq, m_irq);
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    #1;
    chk($sformatf("pslverr_w@%0h", a), pslverr, m_err(a));
    chk("pready", pready, 1'b1);
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] v);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    #1;
    v = prdata;
    chk($sformatf("prdata@%0h", a), prdata, m_read(a));
    chk($sformatf("pslverr_r@%0h", a), pslverr, m_err(a));
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  function automatic logic [11:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8) return 12'(r * 4 + int'($urandom_range(0, 3)));
    if (r == 8) return 12'(256 + 4 * int'($urandom_range(0, 17)));
    return 12'(512 + 4 * int'($urandom_range(0, 255)));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gpio_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_gpio_out", gpio_out, 16'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", pslverr, 1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("rst_ctl%0d", i), gpio_ctl[i*W +: W], 9'h003);
    rst_n = 1'b1;
    tick();
    apb_read(12'h114, v);
    chk("ctl5_read", v, 32'h003);
    apb_read(12'h004, v);
    chk("din_read", v, 32'h0);

    // DOUT, DOUT_SET, DOUT_CLR
    apb_write(12'h000, 32'h00F0);
    apb_write(12'h018, 32'h0003);
    apb_write(12'h01C, 32'h0010);
    chk("dout_e3", gpio_out, 16'h00E3);
    apb_read(12'h018, v);
    chk("set_reads0", v, 32'h0);
    apb_read(12'h01C, v);
    chk("clr_reads0", v, 32'h0);

    // Pad control word and out-of-range CTL index
    apb_write(12'h108, 32'h1F0);
    chk("ctl2_slice", gpio_ctl[26:18], 9'h1F0);
    chk("ctl01_slice", gpio_ctl[17:0], {9'h003, 9'h003});
    apb_write(12'h140, 32'hFFFF_FFFF);
    apb_write(12'h200, 32'hFFFF_FFFF);
    chk("ctl_after_bad", gpio_ctl[N*W-1:27], {13{9'h003}});

    // Rising edge on bit 0: DIN after 2 edges, ISTAT on 3rd, irq on 4th
    apb_write(12'h00C, 32'h1);
    apb_write(12'h008, 32'h1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h004;
    gpio_in[0] = 1'b1;
    tick();
    chk("din_e1", prdata[0], 1'b0);
    tick();
    chk("din_e2", prdata[0], 1'b1);
    paddr = 12'h014;
    #1;
    chk("istat_e2", prdata, 32'h0);
    tick();
    chk("istat_e3", prdata, 32'h1);
    chk("irq_e3", irq, 1'b0);
    tick();
    chk("irq_e4", irq, 1'b1);
    psel = 1'b0; penable = 1'b0;
    apb_write(12'h014, 32'h1);
    tick();
    chk("irq_cleared", irq, 1'b0);

    // Falling edge on bit 3 latches with IE off; enabling IE raises irq
    gpio_in[3] = 1'b1;
    repeat (4) tick();
    apb_write(12'h010, 32'h8);
    apb_write(12'h008, 32'h0);
    gpio_in[3] = 1'b0;
    repeat (4) tick();
    apb_read(12'h014, v);
    chk("istat3", v[3], 1'b1);
    chk("irq_masked", irq, 1'b0);
    apb_write(12'h008, 32'h8);
    tick();
    chk("irq_unmasked", irq, 1'b1);

    // W1C in the same cycle as a new rising edge on bit 0
    gpio_in[0] = 1'b0;
    repeat (4) tick();
    gpio_in[0] = 1'b1;
    tick();
    apb_write(12'h014, 32'h1);
    apb_read(12'h014, v);
    chk("set_wins", v[0], 1'b1);

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 4))
        0: begin gpio_in = N'($urandom); tick(); end
        1: apb_write(pick_addr(), $urandom);
        2: apb_read(pick_addr(), v);
        3: apb_write(12'h014, $urandom);
        default: apb_write(12'(4 * int'($urandom_range(2, 4))), $urandom);
      endcase
    end

    // Reset asserted during the access phase of a DOUT write
    apb_write(12'h000, 32'hA5A5);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hFFFF;
    tick();
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_async", gpio_out, 16'h0);
    chk("abort_irq", irq, 1'b0);
    @(posedge clk);
    #1;
    chk("abort_edge", gpio_out, 16'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst_n = 1'b1;
    tick();
    apb_read(12'h000, v);
    chk("abort_dout", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
